// File: rtl/scan_mux_n.sv
// scan_mux_n: NCH:1 multiplexer of WIDTH-bit channels with a registered,
// valid/ready output stage. Manual mode forwards the channel picked by sel;
// auto-sweep mode walks every channel once per start pulse.
// Optional build macro SCAN_MASK_EN adds a per-channel enable mask.
module scan_mux_n #(
    parameter int WIDTH = 1,
    parameter int NCH   = 16,
    parameter int SELW  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    input  logic                 start,
`ifdef SCAN_MASK_EN
    input  logic [NCH-1:0]       mask,
`endif
    output logic [WIDTH-1:0]     out,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t          state, state_nx;
    logic [SELW-1:0] ptr, ptr_nx;
    logic            busy_nx, done_nx;
    logic            ld, load, sel_ok;
    logic [SELW-1:0] load_ch;
    logic [SELW:0]   hit;       // {found, index}
    logic [NCH-1:0]  en;        // channels enabled for the running sweep
    logic [NCH-1:0]  start_en;  // channels enabled for a sweep launched now

    // Lowest enabled channel at or above lo; MSB flags whether one exists.
    function automatic logic [SELW:0] find_from(input logic [NCH-1:0] e, input int lo);
        logic [SELW:0] r;
        r = '0;
        for (int k = NCH - 1; k >= 0; k--)
            if (e[k] && k >= lo) r = {1'b1, SELW'(k)};
        return r;
    endfunction

    // The register may take a new word when it is empty or being drained.
    assign ld = !out_valid || out_ready;

`ifdef SCAN_MASK_EN
    logic [NCH-1:0] mask_q;

    // Mask is frozen for the whole sweep at the moment it is launched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  mask_q <= '0;
        else if (state == IDLE && mode && start)  mask_q <= mask;
    end

    assign en       = mask_q;
    assign start_en = mask;
    assign sel_ok   = (int'(sel) < NCH) && mask[sel];
`else
    assign en       = '1;
    assign start_en = '1;
    assign sel_ok   = int'(sel) < NCH;
`endif

    // Next-state, sweep pointer and load decision.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        busy_nx  = busy;
        done_nx  = 1'b0;
        load     = 1'b0;
        load_ch  = out_ch;
        hit      = '0;
        unique case (state)
            IDLE: begin
                if (!mode) begin
                    if (ld && sel_ok) begin
                        load    = 1'b1;
                        load_ch = sel;
                    end
                end else if (start) begin
                    // Pointer starts on the first enabled channel; an empty
                    // sweep finishes immediately without entering SCAN.
                    hit = find_from(start_en, 0);
                    if (hit[SELW]) begin
                        ptr_nx   = hit[SELW-1:0];
                        busy_nx  = 1'b1;
                        state_nx = SCAN;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (ld) begin
                    load    = 1'b1;
                    load_ch = ptr;
                    hit     = find_from(en, int'(ptr) + 1);
                    if (hit[SELW]) begin
                        ptr_nx = hit[SELW-1:0];
                    end else begin
                        ptr_nx   = '0;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

    // Output register: load a new word, or hold it until it is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (load) begin
                out    <= in[load_ch*WIDTH +: WIDTH];
                out_ch <= load_ch;
            end
            out_valid <= load || (out_valid && !ld);
        end
    end

endmodule
